tdm_demux_4: RTL and testbench
==============================

TDM_DEMUX_4 -- requirements
Module: tdm_demux_4

Interface
REQ-001 The block SHALL have no parameters; lane count is fixed at 4 and slot index width at 2.
REQ-002 Clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Reset_n  input  1  synchronous, active-low reset, sampled on rising edge of Clk.
REQ-004 In  input  1  serial data bit to be routed to one of four lanes.
REQ-005 In_valid  input  1  In is valid this cycle; one bit consumed per cycle when high.
REQ-006 Sel  input  2  lane index used in direct mode only.
REQ-007 Mode  input  1  0 = direct (Sel-addressed), 1 = TDM frame (auto slot counter).
REQ-008 Sync  input  1  frame-start marker in TDM mode, qualified by In_valid; ignored in direct mode.
REQ-009 Out  output  4  registered lane outputs; Out[k] is lane k.
REQ-010 Out_valid  output  1  one-cycle pulse, Out was updated at the preceding edge.
REQ-011 Slot  output  2  current TDM slot counter (next slot to be written).
REQ-012 Frame_err  output  1  one-cycle pulse, a partial TDM frame was discarded.

Function
REQ-013 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-014 Direct mode: at an edge with In_valid=1, Out[Sel] <= In, other Out bits hold; Out_valid=1 for the following cycle.
REQ-015 Direct mode: In_valid=0 SHALL leave Out unchanged and Out_valid=0; FSM held in IDLE, Slot held at 0.
REQ-016 TDM mode SHALL use a 2-state FSM: IDLE (waiting for Sync) and RUN (collecting frame).
REQ-017 IDLE: In_valid=1 with Sync=0 SHALL be discarded; In_valid=1 with Sync=1 SHALL write shadow[0]<=In, Slot<=1, go to RUN.
REQ-018 RUN: each In_valid=1 with Sync=0 SHALL write shadow[Slot]<=In and Slot<=Slot+1 mod 4.
REQ-019 RUN, write at Slot=3: Out <= {In, shadow[2], shadow[1], shadow[0]} in a single edge, Out_valid=1 next cycle, Slot wraps to 0, stay RUN.
REQ-020 Out SHALL change only on frame completion in TDM mode; partial frames never visible on Out.
REQ-021 RUN, Sync=1 with In_valid=1 at Slot=0: treated as normal slot-0 write, no error.
REQ-022 RUN, Sync=1 with In_valid=1 at Slot!=0: discard shadow, Frame_err=1 next cycle, write shadow[0]<=In, Slot<=1, stay RUN.
REQ-023 Sync=1 with In_valid=0 SHALL be ignored in all states.
REQ-024 In_valid=0 in RUN SHALL hold Slot and shadow (gaps allowed, no timeout).
REQ-025 Any change of Mode (sampled vs previous cycle) SHALL force IDLE, Slot<=0, clear shadow; Out holds; input on that cycle is processed under the new Mode only if the new Mode is direct.
REQ-026 Out_valid and Frame_err SHALL be low in every cycle not explicitly specified above; both may be high together only never (REQ-022 never completes a frame).

Reset
REQ-027 Reset_n=0 at an edge SHALL set Out=4'b0000, Out_valid=0, Frame_err=0, Slot=0, shadow=0, FSM=IDLE; reset overrides all other inputs.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; first frame after release requires Sync.

Verification
REQ-029 Reset check: hold Reset_n=0 2 cycles with In_valid=1, In=1 -> Out=0000, Out_valid=0, Slot=0, Frame_err=0.
REQ-030 Direct mode: Mode=0, writes (Sel,In)=(2,1),(0,1),(2,0) on consecutive cycles -> Out=0100, 0101, 0001 with Out_valid high each following cycle.
REQ-031 TDM frame: Mode=1, Sync on first, bits 1,0,1,1 in slots 0..3 with one idle gap after slot 1 -> Out=1101 only after slot 3, single Out_valid pulse, Slot sequence 1,2,2,3,0.
REQ-032 Resync error: Mode=1, Sync+bits 1,1, then Sync with bit 0 followed by 0,1,0 -> Frame_err pulse once, Out=0100, Out unchanged before completion.
REQ-033 Pre-sync discard: Mode=1 after reset, 3 bits with Sync=0 then Sync frame 0,1,1,0 -> Out=0110, Out_valid exactly once.
REQ-034 Mode switch and reset mid-frame: Mode=1 frame at Slot=2, toggle Mode to 0 (or pulse Reset_n) -> Slot=0, IDLE, Out retains prior value (or 0000 on reset), no Out_valid.

Source files
------------

// File: rtl/tdm_demux_4.sv
// Four-lane serial demultiplexer: direct Sel-addressed writes, or TDM frames
// collected in a shadow register and published to Out only on frame completion.
module tdm_demux_4 (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       In,
  input  logic       In_valid,
  input  logic [1:0] Sel,
  input  logic       Mode,
  input  logic       Sync,
  output logic [3:0] Out,
  output logic       Out_valid,
  output logic [1:0] Slot,
  output logic       Frame_err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e     state_q, state_d;
  logic [3:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic       frame_err_q, frame_err_d;
  logic [1:0] slot_q, slot_d;
  // Only slots 0..2 need storage; slot 3 lands straight in Out.
  logic [2:0] shadow_q, shadow_d;
  logic       mode_q, mode_d;
  logic       mode_chg;

  assign mode_chg = (Mode != mode_q);

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    mode_d      = Mode;

    if (mode_chg || !Mode) begin
      // Direct mode, or any mode transition: frame state is abandoned.
      state_d = StIdle;
      slot_d  = 2'd0;
      if (mode_chg) begin
        shadow_d = 3'b000;
      end
      if (!Mode && In_valid) begin
        out_d[Sel]  = In;
        out_valid_d = 1'b1;
      end
    end else if (In_valid) begin
      unique case (state_q)
        StIdle: begin
          if (Sync) begin
            shadow_d = {2'b00, In};
            slot_d   = 2'd1;
            state_d  = StRun;
          end
        end
        StRun: begin
          if (Sync && (slot_q != 2'd0)) begin
            // Resync mid-frame: drop the partial frame and restart at slot 0.
            frame_err_d = 1'b1;
            shadow_d    = {2'b00, In};
            slot_d      = 2'd1;
          end else begin
            slot_d = slot_q + 2'd1;
            case (slot_q)
              2'd0: shadow_d[0] = In;
              2'd1: shadow_d[1] = In;
              2'd2: shadow_d[2] = In;
              default: begin
                out_d       = {In, shadow_q};
                out_valid_d = 1'b1;
              end
            endcase
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      out_q       <= 4'b0000;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      slot_q      <= 2'd0;
      shadow_q    <= 3'b000;
      // Track the mode seen during reset so release is not treated as a mode change.
      mode_q      <= Mode;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      mode_q      <= mode_d;
    end
  end

  assign Out       = out_q;
  assign Out_valid = out_valid_q;
  assign Slot      = slot_q;
  assign Frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed self-checking bench for tdm_demux_4.
module tb_tdm_demux_4;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       In;
  logic       In_valid;
  logic [1:0] Sel;
  logic       Mode;
  logic       Sync;
  logic [3:0] Out;
  logic       Out_valid;
  logic [1:0] Slot;
  logic       Frame_err;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  tdm_demux_4 dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .In        (In),
    .In_valid  (In_valid),
    .Sel       (Sel),
    .Mode      (Mode),
    .Sync      (Sync),
    .Out       (Out),
    .Out_valid (Out_valid),
    .Slot      (Slot),
    .Frame_err (Frame_err)
  );

  // Apply one cycle of inputs, then sample 1ns after the rising edge.
  task automatic step(input logic v, input logic b, input logic [1:0] s, input logic sy);
    In_valid = v;
    In       = b;
    Sel      = s;
    Sync     = sy;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    Mode    = 1'b0;
    step(1'b1, 1'b1, 2'd1, 1'b0);
    step(1'b1, 1'b1, 2'd1, 1'b0);
    total++;
    if (Out !== 4'b0000 || Out_valid !== 1'b0 || Slot !== 2'd0 || Frame_err !== 1'b0) begin
      $display("FAIL reset: Out=%b ov=%b Slot=%0d fe=%b, required 0000 0 0 0",
               Out, Out_valid, Slot, Frame_err);
      bad++;
    end
    Reset_n = 1'b1;
    step(1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_direct;
    logic [3:0] exp_out [3];
    logic [1:0] sels    [3];
    logic       bits    [3];
    exp_out = '{4'b0100, 4'b0101, 4'b0001};
    sels    = '{2'd2, 2'd0, 2'd2};
    bits    = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, bits[i], sels[i], 1'b0);
      total++;
      if (Out !== exp_out[i] || Out_valid !== 1'b1) begin
        $display("FAIL direct[%0d]: Out=%b ov=%b, required %b 1", i, Out, Out_valid, exp_out[i]);
        bad++;
      end
    end
    step(1'b0, 1'b1, 2'd3, 1'b1);
    total++;
    if (Out !== 4'b0001 || Out_valid !== 1'b0 || Slot !== 2'd0) begin
      $display("FAIL direct_idle: Out=%b ov=%b Slot=%0d, required 0001 0 0", Out, Out_valid, Slot);
      bad++;
    end
  endtask

  task automatic test_tdm_frame;
    logic       vs    [5];
    logic       bits  [5];
    logic       syncs [5];
    logic [1:0] slots [5];
    int         pulses;
    Mode = 1'b1;
    step(1'b0, 1'b0, 2'd0, 1'b0);  // mode-change cycle
    vs    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bits  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    syncs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    slots = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(vs[i], bits[i], 2'd0, syncs[i]);
      if (Out_valid === 1'b1) pulses++;
      total++;
      if (Slot !== slots[i] || Frame_err !== 1'b0) begin
        $display("FAIL tdm_slot[%0d]: Slot=%0d fe=%b, required %0d 0", i, Slot, Frame_err, slots[i]);
        bad++;
      end
      if (i < 4) begin
        total++;
        if (Out !== 4'b0001) begin
          $display("FAIL tdm_hold[%0d]: Out=%b, required 0001", i, Out);
          bad++;
        end
      end
    end
    total++;
    if (Out !== 4'b1101 || Out_valid !== 1'b1 || pulses != 1) begin
      $display("FAIL tdm_frame: Out=%b ov=%b pulses=%0d, required 1101 1 1", Out, Out_valid, pulses);
      bad++;
    end
    step(1'b0, 1'b0, 2'd0, 1'b0);
    total++;
    if (Out_valid !== 1'b0 || Out !== 4'b1101) begin
      $display("FAIL tdm_after: Out=%b ov=%b, required 1101 0", Out, Out_valid);
      bad++;
    end
  endtask

  task automatic test_resync;
    logic bits  [6];
    logic syncs [6];
    int   errs;
    int   pulses;
    // Already in RUN at slot 0: Sync here is a normal slot-0 write.
    bits  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    syncs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    errs   = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, bits[i], 2'd0, syncs[i]);
      if (Frame_err === 1'b1) errs++;
      if (Out_valid === 1'b1) pulses++;
      if (i == 2) begin
        total++;
        if (Frame_err !== 1'b1 || Slot !== 2'd1 || Out !== 4'b1101) begin
          $display("FAIL resync_err: fe=%b Slot=%0d Out=%b, required 1 1 1101", Frame_err, Slot, Out);
          bad++;
        end
      end
      if (i < 5) begin
        total++;
        if (Out !== 4'b1101) begin
          $display("FAIL resync_hold[%0d]: Out=%b, required 1101", i, Out);
          bad++;
        end
      end
    end
    total++;
    if (Out !== 4'b0100 || Out_valid !== 1'b1 || errs != 1 || pulses != 1) begin
      $display("FAIL resync_frame: Out=%b ov=%b errs=%0d pulses=%0d, required 0100 1 1 1",
               Out, Out_valid, errs, pulses);
      bad++;
    end
  endtask

  task automatic test_presync;
    logic bits  [7];
    logic syncs [7];
    int   pulses;
    Reset_n = 1'b0;
    Mode    = 1'b1;
    step(1'b0, 1'b0, 2'd0, 1'b0);
    Reset_n = 1'b1;
    bits  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    syncs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, bits[i], 2'd0, syncs[i]);
      if (Out_valid === 1'b1) pulses++;
      if (i < 3) begin
        total++;
        if (Slot !== 2'd0 || Out !== 4'b0000) begin
          $display("FAIL presync_discard[%0d]: Slot=%0d Out=%b, required 0 0000", i, Slot, Out);
          bad++;
        end
      end
    end
    total++;
    if (Out !== 4'b0110 || pulses != 1) begin
      $display("FAIL presync_frame: Out=%b pulses=%0d, required 0110 1", Out, pulses);
      bad++;
    end
  endtask

  task automatic test_mode_switch;
    step(1'b1, 1'b1, 2'd0, 1'b1);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    total++;
    if (Slot !== 2'd2) begin
      $display("FAIL mode_setup: Slot=%0d, required 2", Slot);
      bad++;
    end
    Mode = 1'b0;
    step(1'b0, 1'b0, 2'd0, 1'b0);
    total++;
    if (Slot !== 2'd0 || Out !== 4'b0110 || Out_valid !== 1'b0) begin
      $display("FAIL mode_switch: Slot=%0d Out=%b ov=%b, required 0 0110 0", Slot, Out, Out_valid);
      bad++;
    end
    Mode = 1'b1;
    step(1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 1'b0);  // no Sync: must be discarded in IDLE
    total++;
    if (Slot !== 2'd0 || Out_valid !== 1'b0) begin
      $display("FAIL mode_idle: Slot=%0d ov=%b, required 0 0", Slot, Out_valid);
      bad++;
    end
    step(1'b0, 1'b1, 2'd0, 1'b1);  // Sync without valid is ignored
    total++;
    if (Slot !== 2'd0) begin
      $display("FAIL sync_novalid: Slot=%0d, required 0", Slot);
      bad++;
    end
    Mode = 1'b0;
    step(1'b1, 1'b1, 2'd3, 1'b0);  // switch to direct processes input same cycle
    total++;
    if (Out !== 4'b1110 || Out_valid !== 1'b1 || Slot !== 2'd0) begin
      $display("FAIL switch_direct: Out=%b ov=%b Slot=%0d, required 1110 1 0", Out, Out_valid, Slot);
      bad++;
    end
  endtask

  task automatic test_reset_midframe;
    Mode = 1'b1;
    step(1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 1'b1);
    step(1'b1, 1'b1, 2'd0, 1'b0);
    total++;
    if (Slot !== 2'd2) begin
      $display("FAIL rst_setup: Slot=%0d, required 2", Slot);
      bad++;
    end
    Reset_n = 1'b0;
    step(1'b1, 1'b1, 2'd0, 1'b0);
    total++;
    if (Out !== 4'b0000 || Slot !== 2'd0 || Out_valid !== 1'b0 || Frame_err !== 1'b0) begin
      $display("FAIL rst_midframe: Out=%b Slot=%0d ov=%b fe=%b, required 0000 0 0 0",
               Out, Slot, Out_valid, Frame_err);
      bad++;
    end
    Reset_n = 1'b1;
    step(1'b1, 1'b1, 2'd0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 1'b0);
    total++;
    if (Slot !== 2'd0 || Out_valid !== 1'b0) begin
      $display("FAIL rst_needsync: Slot=%0d ov=%b, required 0 0", Slot, Out_valid);
      bad++;
    end
  endtask

  initial begin
    Reset_n  = 1'b0;
    In       = 1'b0;
    In_valid = 1'b0;
    Sel      = 2'd0;
    Mode     = 1'b0;
    Sync     = 1'b0;
    test_reset();
    test_direct();
    test_tdm_frame();
    test_resync();
    test_presync();
    test_mode_switch();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
